vga_scanout: RTL and testbench
==============================

# vga_scanout

Display-side reader for the core's `draw` path. It holds a 320x240, 3-bit-per-pixel framebuffer that the core writes through a simple write port. It scans that framebuffer out as 640x480@60 VGA, doubling each pixel in both directions. It drives the board's `O_HSYNC`, `O_VSYNC` and `O_VIDEO_R/G/B` pins, which the core currently ties to 0.

## Interface
Parameters:
- `CLK_DIV`, default 2: CLK cycles per VGA pixel (50 MHz CLK gives 25 MHz pixel rate); must be ≥1.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal timing, in pixels.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical timing, in lines.

Ports:
- `CLK`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `I_RESET`  in  1  asynchronous, active-high reset.
- `I_WE`  in  1  framebuffer write strobe, sampled on CLK rising edge.
- `I_WADDR`  in  17  pixel index, y*320 + x.
- `I_WDATA`  in  3  colour: bit2 = R, bit1 = G, bit0 = B.
- `O_HSYNC`  out  1  horizontal sync, active low.
- `O_VSYNC`  out  1  vertical sync, active low.
- `O_VIDEO_R`, `O_VIDEO_G`, `O_VIDEO_B`  out  4 each  colour channels; each is 4'hF or 4'h0.
- `O_FRAME_START`  out  1  one-CLK pulse when the timing counters wrap to (0,0).

## Operation
- **Pixel enable:**
  - A divider counts 0..CLK_DIV-1 and asserts `pix_en` on terminal count.
  - The h/v counters advance only on `pix_en`.
- **h_cnt:**
  - Range 0..799.
  - Wraps to 0 on `pix_en` at 799 and increments v_cnt.
- **v_cnt:**
  - Range 0..524.
  - Wraps to 0 when h_cnt wraps with v_cnt at 524.
- **Regions:**
  - Active video: h_cnt < 640 and v_cnt < 480.
  - HSYNC low: h_cnt in [656, 751].
  - VSYNC low: v_cnt in [490, 491].
- **Read address:** `row_base + (h_cnt >> 1)`.
  - `row_base` is a 17-bit register, with no multiplier.
  - Cleared at v_cnt wrap.
  - Increased by 320 on each h_cnt wrap where v_cnt[0] = 1 and v_cnt < 480.
- **Blanking:** outside active video, RGB is forced to 0 regardless of RAM data.
- **Colour expansion:** each data bit is replicated to 4 bits: R = {4{d[2]}}, G = {4{d[1]}}, B = {4{d[0]}}.
- **Writes:**
  - A write occurs when `I_WE` is high and `I_WADDR` < 76800.
  - `I_WADDR` ≥ 76800 is ignored, with no aliasing.
  - Writes are accepted every CLK, independent of scan position; there is no backpressure.
- **Read/write collision:** a simultaneous read and write to the same address returns the old data (read-first). The new data is visible from the next read.
- **Reset:**
  - Clears the divider, counters, row_base and all pipeline registers.
  - Does not clear RAM contents.
  - The scan restarts at (0,0) after reset deasserts.
- **Reset values:**
  - `O_HSYNC` = 1, `O_VSYNC` = 1.
  - RGB = 0.
  - `O_FRAME_START` = 0.

## Timing
- The output pipeline advances every CLK and is not gated by `pix_en`. It has 3 stages:
  - S1: registered read address, active flag, hsync, vsync.
  - S2: synchronous RAM read data, with the S1 flags delayed one stage.
  - S3: output registers.
- Latency is exactly 3 CLK from a counter value to the matching pins. Syncs and colour travel the same pipeline, so they stay aligned.
- At CLK_DIV = 2:
  - Line period is 1600 CLK; HSYNC is low for 192 CLK.
  - Frame period is 840000 CLK; VSYNC is low for 3200 CLK.
- `O_FRAME_START` is registered. It pulses in the CLK after the counters reach (0,0) at the `pix_en` edge, i.e. 2 CLK before pixel (0,0) reaches the pins.
- A write completes at the CLK edge where `I_WE` is sampled. It is visible on screen from the next scan of that pixel.

## Structure
- **Shared package `vga_pkg`:**
  - The timing constants above.
  - FB_W = 320, FB_H = 240, FB_DEPTH = 76800, FB_AW = 17.
  - A 3-bit colour type.
- **Sub-module `fb_ram`:**
  - Simple dual-port, 76800x3, one write port and one synchronous read port, read-first.
  - Inferred block RAM, with no reset on its contents.
- **`vga_scanout` itself:** the divider, the counters, row_base, the pipeline and the colour expansion.

## Test plan
- **Reset values:** assert `I_RESET` asynchronously mid-CLK -> immediately HSYNC = VSYNC = 1 and RGB = 0. Release -> the first HSYNC falling edge occurs (656 × 2) + 3 CLK later.
- **Sync timing:** run 2 frames at CLK_DIV = 2 ->
  - HSYNC period 1600 CLK, low 192 CLK.
  - VSYNC low for exactly 2 lines, starting at line 490.
  - `O_FRAME_START` pulses once per 840000 CLK.
- **Top-left pixel:** write addr 0, data 3'b100 -> R = 4'hF, G = B = 0.
  - Lit for screen x 0..1 on screen lines 0 and 1 only (4 CLK per line).
  - Screen x = 2 is black.
- **Last pixel:** write addr 76799, data 3'b111 -> white at screen x 638..639, lines 478..479. Blank (RGB = 0) from x = 640 onward.
- **Out-of-range write:** write addr 76800, data 3'b111 with addr 0 pre-set to 3'b000 -> no pixel anywhere changes.
- **Collision and mid-frame reset:** write a pixel on the same CLK it is being read -> the old colour shows this frame and the new colour next frame. Then reset at line 100 -> outputs go to reset values, scan restarts at (0,0), and the written pixel persists.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, framebuffer geometry and colour helpers.
//   No ports; imported by fb_ram and vga_scanout.
package vga_pkg;
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int FB_W       = 320;
    localparam int FB_H       = 240;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int FB_AW      = 17;

    typedef logic [2:0] color_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Each colour bit drives a whole 4-bit DAC channel fully on or off.
    function automatic rgb_t expand(input color_t c);
        return '{r: {4{c[2]}}, g: {4{c[1]}}, b: {4{c[0]}}};
    endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port framebuffer, one write port and one synchronous read-first read port.
//   clk_i              clock
//   we_i/waddr_i/wdata_i  write strobe, pixel index, colour; indices >= DEPTH are dropped
//   raddr_i/rdata_o    read index and colour, one clock of latency
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [2:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [2:0]    rdata_o
);
    color_t mem [DEPTH];

    // Read and write share one block so a same-address access returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i < AW'(DEPTH)) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: scans a 320x240 3-bit framebuffer out as pixel-doubled VGA.
//   CLK, I_RESET               clock, asynchronous active-high reset
//   I_WE, I_WADDR, I_WDATA     framebuffer write port (index y*320+x, colour {R,G,B})
//   O_HSYNC, O_VSYNC           active-low syncs
//   O_VIDEO_R/G/B              4-bit channels, all-ones or zero
//   O_FRAME_START              one-clock pulse after the scan wraps to (0,0)
module vga_scanout
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic             CLK,
    input  logic             I_RESET,
    input  logic             I_WE,
    input  logic [FB_AW-1:0] I_WADDR,
    input  logic [2:0]       I_WDATA,
    output logic             O_HSYNC,
    output logic             O_VSYNC,
    output logic [3:0]       O_VIDEO_R,
    output logic [3:0]       O_VIDEO_G,
    output logic [3:0]       O_VIDEO_B,
    output logic             O_FRAME_START
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_END   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_END   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC - 1);

    logic [DW-1:0]    div_q, div_d;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic [FB_AW-1:0] row_q, row_d;
    logic             pix_en, h_wrap, v_wrap;
    logic             wrap_q, fs_q;
    logic [FB_AW-1:0] addr_q;
    logic             act1_q, hs1_q, vs1_q;
    logic             act2_q, hs2_q, vs2_q;
    color_t           rd_data;
    rgb_t             rgb_q;
    logic             hs_q, vs_q;

    // row_base steps one framebuffer row every second visible line, giving
    // vertical doubling without a multiplier.
    always_comb begin
        pix_en = div_q == DIV_END;
        h_wrap = pix_en && h_q == H_END;
        v_wrap = h_wrap && v_q == V_END;
        div_d  = pix_en ? '0 : div_q + DW'(1);
        h_d    = h_wrap ? '0 : h_q + HW'(pix_en);
        v_d    = v_wrap ? '0 : v_q + VW'(h_wrap);
        row_d  = v_wrap ? '0
               : (h_wrap && v_q[0] && v_q < V_ACT) ? row_q + FB_AW'(FB_W)
               : row_q;
    end

    // Pipeline runs every clock: S1 address/flags, S2 RAM data, S3 pins.
    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            row_q  <= '0;
            wrap_q <= 1'b0;
            fs_q   <= 1'b0;
            addr_q <= '0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            act2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            row_q  <= row_d;
            wrap_q <= v_wrap;
            fs_q   <= wrap_q;
            addr_q <= row_q + FB_AW'(h_q >> 1);
            act1_q <= h_q < H_ACT && v_q < V_ACT;
            hs1_q  <= !(h_q >= HS_BEG && h_q <= HS_END);
            vs1_q  <= !(v_q >= VS_BEG && v_q <= VS_END);
            act2_q <= act1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= act2_q ? expand(rd_data) : '0;
            hs_q   <= hs2_q;
            vs_q   <= vs2_q;
        end
    end

    fb_ram u_fb (
        .clk_i   (CLK),
        .we_i    (I_WE),
        .waddr_i (I_WADDR),
        .wdata_i (I_WDATA),
        .raddr_i (addr_q),
        .rdata_o (rd_data)
    );

    assign O_HSYNC       = hs_q;
    assign O_VSYNC       = vs_q;
    assign O_VIDEO_R     = rgb_q.r;
    assign O_VIDEO_G     = rgb_q.g;
    assign O_VIDEO_B     = rgb_q.b;
    assign O_FRAME_START = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks vga_scanout against a cycle-count model on a reduced timing set.
module tb_vga_scanout;
    localparam int CD = 2;
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = CD * HT * VT;

    logic        clk, rst, we;
    logic [16:0] waddr;
    logic [2:0]  wdata;
    logic        hsync, vsync, fstart;
    logic [3:0]  vr, vg, vb;

    int total = 0, bad = 0;
    int n = 0, tick = 0;

    typedef struct {
        int         t;
        int         a;
        logic [2:0] d;
    } wr_t;
    wr_t        wq[$];
    logic [2:0] mfb [0:76799];

    vga_scanout #(
        .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .CLK(clk), .I_RESET(rst), .I_WE(we), .I_WADDR(waddr), .I_WDATA(wdata),
        .O_HSYNC(hsync), .O_VSYNC(vsync),
        .O_VIDEO_R(vr), .O_VIDEO_G(vg), .O_VIDEO_B(vb),
        .O_FRAME_START(fstart)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) n = 0;
        else n++;
    end

    always @(posedge clk) begin
        tick++;
        if (we === 1'b1 && waddr < 17'd76800) wq.push_back('{tick, int'(waddr), wdata});
    end

    // Model: pins after edge n show the scan position of edge n-3; a write
    // sampled at edge T is visible on pins from edge T+2 onward.
    always @(negedge clk) begin
        logic [14:0] e, a;
        logic [2:0]  c;
        logic        eh, ev, ef;
        logic [11:0] rgb;
        int          p, h, v, m;
        while (wq.size() > 0 && wq[0].t <= tick - 2) begin
            mfb[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
        end
        eh = 1; ev = 1; ef = 0; rgb = 0;
        if (!rst) begin
            if (n >= 3) begin
                p  = (n - 3) / CD;
                h  = p % HT;
                v  = (p / HT) % VT;
                eh = !(h >= HV + HF && h < HV + HF + HS);
                ev = !(v >= VV + VF && v < VV + VF + VS);
                if (h < HV && v < VV) begin
                    c   = mfb[(v / 2) * 320 + h / 2];
                    rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
                end
            end
            m  = n - 1;
            ef = m >= 1 && m % CD == 0 && (m / CD) % (HT * VT) == 0;
        end
        e = {eh, ev, ef, rgb};
        a = {hsync, vsync, fstart, vr, vg, vb};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL scan n=%0d got=%h exp=%h", n, a, e);
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [2:0] d);
        @(negedge clk);
        we = 1; waddr = 17'(a); wdata = d;
        @(negedge clk);
        we = 0;
    endtask

    task automatic wait_n(input int t);
        int g = 0;
        while (n < t && g < 5000) begin
            @(posedge clk); #1; g++;
        end
        check("wait_n", n, t);
    endtask

    task automatic wait_sig(input string nm, input int sel, input logic lvl, input int exp);
        int   g = 0;
        logic s;
        do begin
            @(posedge clk); #1; g++;
            s = sel == 0 ? hsync : sel == 1 ? vsync : fstart;
        end while (s !== lvl && g < 3000);
        check(nm, n, exp);
    endtask

    task automatic frame_counts(input int k, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        wait_n(FR * k + 2);
        repeat (FR) begin
            @(posedge clk); #1;
            r += int'(vr != 0);
            g += int'(vg != 0);
            b += int'(vb != 0);
        end
    endtask

    initial begin
        int r, g, b;
        for (int i = 0; i < 76800; i++) mfb[i] = 0;
        rst = 1; we = 0; waddr = 0; wdata = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) wr((i / 8) * 320 + i % 8, 3'b000);
        wr(0, 3'b100);
        @(posedge clk); #2 rst = 0;

        wait_sig("hs_first_fall", 0, 0, 43);
        wait_sig("hs_rise", 0, 1, 55);
        wait_sig("hs_second_fall", 0, 0, 103);
        wait_sig("vs_fall", 1, 0, 603);
        wait_sig("vs_rise", 1, 1, 723);
        wait_sig("fs_first", 2, 1, 901);
        wait_sig("fs_second", 2, 1, 1801);

        frame_counts(2, r, g, b);
        check("tl_red", r, 8);
        check("tl_green", g, 0);
        check("tl_blue", b, 0);

        wr(3 * 320 + 7, 3'b111);
        frame_counts(4, r, g, b);
        check("last_red", r, 16);
        check("last_green", g, 8);
        check("last_blue", b, 8);

        wr(0, 3'b000);
        wr(3 * 320 + 7, 3'b000);
        wr(76800, 3'b111);
        frame_counts(6, r, g, b);
        check("oor_red", r, 0);
        check("oor_green", g, 0);
        check("oor_blue", b, 0);

        wr(4, 3'b010);
        fork
            frame_counts(8, r, g, b);
            begin
                wait_n(FR * 8 + 80);
                we = 1; waddr = 17'd4; wdata = 3'b001;
                @(posedge clk); #1;
                we = 0;
            end
        join
        check("coll_old_green", g, 8);
        check("coll_old_blue", b, 0);
        frame_counts(9, r, g, b);
        check("coll_new_green", g, 0);
        check("coll_new_blue", b, 8);

        wait_n(FR * 10 + 347);
        check("pre_reset_hs", int'(hsync), 0);
        #2 rst = 1;
        #1;
        check("rst_hs", int'(hsync), 1);
        check("rst_vs", int'(vsync), 1);
        check("rst_rgb", int'({vr, vg, vb}), 0);
        check("rst_fs", int'(fstart), 0);
        repeat (3) @(posedge clk);
        #2 rst = 0;
        fork
            frame_counts(0, r, g, b);
            wait_sig("restart_hs_fall", 0, 0, 43);
        join
        check("restart_red", r, 0);
        check("restart_green", g, 0);
        check("restart_blue", b, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
